decode_output_arbiter: RTL
==========================

Name: decode_output_arbiter

Overview:
- Merges the registered outputs of the format-specific decoders (D, DS, X, XO, …) into one decoded-instruction stream toward rename/dispatch.
- Each source gets a 2-entry holding queue.
- A round-robin arbiter grants one entry per cycle into a registered output stage.
- Per-source stall provides back-pressure to the decoders. Downstream stall freezes the output.

Parameters:
- NumSources, 4, number of decoder outputs merged.
- PayloadWidth, 221, flattened decoder bundle: opcode 12, address 64, funcUnit 3, majId 64, minId 7, is64Bit 1, pid 20, tid 16, op1rw 2, op2rw 2, flags 4, body 26.
- QueueDepth, 2, entries per source queue; fixed at 2 for this revision.
- SrcIdWidth, 2, clog2(NumSources).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  NumSources  bit s = source s presents a valid payload this cycle.
- payload_i  in  NumSources*PayloadWidth  source s occupies bits [s*PayloadWidth +: PayloadWidth].
- stall_o  out  NumSources  back-pressure to source s.
- stall_i  in  1  downstream cannot accept; hold output.
- enable_o  out  1  payload_o valid this cycle.
- payload_o  out  PayloadWidth  granted payload.
- source_o  out  SrcIdWidth  index of the granted source.
- overflow_o  out  1  sticky; a push was dropped on a full queue.

Behaviour:
- Reset (synchronous, sampled on the clock_i rising edge while reset_i=1). Reset values:
  - all queue counts 0, read/write pointers 0;
  - rr pointer = NumSources-1, so source 0 wins first;
  - enable_o=0, payload_o=0, source_o=0, overflow_o=0;
  - stall_o=0, since it is derived from the counts.
- Reset mid-operation discards all queued entries. No enable_o pulses in the cycle after reset.
- Push: enable_i[s]=1 writes payload slice s into queue s at the rising edge.
  - If count[s]==2 and s is not popped that cycle, the push is dropped, overflow_o sets and stays set until reset.
  - A push and a pop of the same queue in one cycle are both performed; count is unchanged.
- Pop/grant:
  - Occurs when stall_i=0 and at least one queue is non-empty. Only the head entries present at the start of the cycle are eligible; a push in the same cycle is not visible.
  - Round-robin search order: rr+1, rr+2, … modulo NumSources. The first non-empty queue wins.
  - On the clock edge: payload_o <= head of winner, source_o <= winner, enable_o <= 1, rr <= winner, count[winner] decrements, read pointer toggles.
  - If stall_i=0 and all queues are empty: enable_o <= 0; payload_o and source_o hold.
  - If stall_i=1: no pop; enable_o, payload_o and source_o all hold their values, and rr holds.
- Latency: a push at edge t produces its earliest enable_o at edge t+1, which is a 1-cycle minimum. Throughput is 1 per cycle aggregate.
- Stall contract: stall_o[s] = (count[s]==2) OR (count[s]==1 AND s not granted this cycle). Combinational from current state and the grant.
  - Each decoder registers its output, so one extra push can land after stall_o rises.
  - The count==1 term guarantees room for that push.
  - A source honouring stall_o never overflows.
- Queue pointers are 1 bit and wrap modulo 2.
- Simultaneous enable_i on several sources is legal; all are queued in the same cycle.
- Ordering is not preserved across sources; it is preserved within a source. Downstream reorders by majId/minId.

Decomposition:
- Shared decode package:
  - PayloadWidth and the field offsets within the bundle;
  - functional-unit IDs (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6);
  - regRead/regWrite encodings.
- One sub-module: decode_holding_queue. It is the 2-entry FIFO with count, push, pop and full, instantiated NumSources times.
- The arbiter, output register and stall logic live in the top level.

Test Plan:
- Reset: assert reset_i for 1 clock with enable_i=4'b1111 → all counts 0, enable_o=0, overflow_o=0, stall_o=4'b0000 on the next cycle.
- Single source: enable_i=4'b0001, majId=5 for 1 cycle → next cycle enable_o=1, source_o=0, payload majId=5. Following cycle enable_o=0.
- Round robin: all 4 sources push once in the same cycle (majId 10..13) → enable_o high for 4 consecutive cycles with source_o=0,1,2,3. stall_o[3]=1 until source 3 is granted.
- Downstream stall: preload sources 0 and 1 with 2 entries each, then stall_i=1 for 5 cycles → payload_o and source_o constant, stall_o[0] and stall_o[1] held at 1. Releasing stall_i drains 4 entries in the order 0,1,0,1.
- Overflow: stall_i=1, push source 2 on 3 consecutive cycles → overflow_o=1 from the cycle after the third push. Only the first 2 payloads emerge after the stall is released.
- Push and pop same queue: source 1 holds count=1, push while it is granted → count stays 1, stall_o[1]=0, no overflow, payloads emerge in push order.

Source files
------------

// File: rtl/decode_output_arbiter_pkg.sv
// rtl/decode_output_arbiter_pkg.sv - shared decode bundle layout, IDs and arbiter sizing
package decode_output_arbiter_pkg;
  localparam int NUM_SOURCES   = 4;
  localparam int PAYLOAD_WIDTH = 221;
  localparam int QUEUE_DEPTH   = 2;
  localparam int SRC_ID_WIDTH  = $clog2(NUM_SOURCES);

  // Field offsets inside the flattened decoder bundle, LSB first.
  localparam int OPCODE_OFF = 0;    localparam int OPCODE_W = 12;
  localparam int ADDR_OFF   = 12;   localparam int ADDR_W   = 64;
  localparam int FU_OFF     = 76;   localparam int FU_W     = 3;
  localparam int MAJ_OFF    = 79;   localparam int MAJ_W    = 64;
  localparam int MIN_OFF    = 143;  localparam int MIN_W    = 7;
  localparam int IS64_OFF   = 150;
  localparam int PID_OFF    = 151;  localparam int PID_W    = 20;
  localparam int TID_OFF    = 171;  localparam int TID_W    = 16;
  localparam int OP1RW_OFF  = 187;  localparam int OP2RW_OFF = 189;
  localparam int FLAGS_OFF  = 191;  localparam int FLAGS_W  = 4;
  localparam int BODY_OFF   = 195;  localparam int BODY_W   = 26;

  typedef enum logic [2:0] {
    FU_FX     = 3'd0,
    FU_FP     = 3'd1,
    FU_VX     = 3'd2,
    FU_CR     = 3'd3,
    FU_LS     = 3'd4,
    FU_BRANCH = 3'd6
  } func_unit_e;

  typedef enum logic [1:0] {
    RW_NONE       = 2'd0,
    RW_READ       = 2'd1,
    RW_WRITE      = 2'd2,
    RW_READ_WRITE = 2'd3
  } reg_rw_e;

  function automatic logic [SRC_ID_WIDTH-1:0] rr_next_idx(input logic [SRC_ID_WIDTH-1:0] base,
                                                          input int step);
    int sum;
    sum = int'(base) + step;
    return SRC_ID_WIDTH'(sum % NUM_SOURCES);
  endfunction
endpackage

// File: rtl/decode_output_arbiter_if.sv
// rtl/decode_output_arbiter_if.sv - decoder-side and rename-side signals of the output arbiter
interface decode_output_arbiter_if;
  import decode_output_arbiter_pkg::*;

  logic [NUM_SOURCES-1:0]               enable_i;
  logic [NUM_SOURCES*PAYLOAD_WIDTH-1:0] payload_i;
  logic [NUM_SOURCES-1:0]               stall_o;
  logic                                 stall_i;
  logic                                 enable_o;
  logic [PAYLOAD_WIDTH-1:0]             payload_o;
  logic [SRC_ID_WIDTH-1:0]              source_o;
  logic                                 overflow_o;

  modport slave (
    input  enable_i, payload_i, stall_i,
    output stall_o, enable_o, payload_o, source_o, overflow_o
  );

  modport master (
    output enable_i, payload_i, stall_i,
    input  stall_o, enable_o, payload_o, source_o, overflow_o
  );
endinterface

// File: rtl/decode_holding_queue.sv
// rtl/decode_holding_queue.sv - 2-entry per-decoder holding FIFO with count and drop flag
module decode_holding_queue
  import decode_output_arbiter_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  logic [WIDTH-1:0] r_mem [QUEUE_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  // A simultaneous pop frees the slot, so a push onto a full queue survives.
  assign o_drop    = i_push && o_full && !w_do_pop;
  assign w_do_push = i_push && !o_drop;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/decode_output_arbiter.sv
// rtl/decode_output_arbiter.sv - round-robin merge of decoder outputs into one registered stream
module decode_output_arbiter
  import decode_output_arbiter_pkg::*;
(
  input logic                     clock_i,
  input logic                     reset_i,
  decode_output_arbiter_if.slave  bus
);
  logic [PAYLOAD_WIDTH-1:0] w_head  [NUM_SOURCES];
  logic [1:0]               w_count [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]   w_full;
  logic [NUM_SOURCES-1:0]   w_empty;
  logic [NUM_SOURCES-1:0]   w_drop;
  logic [NUM_SOURCES-1:0]   w_pop;
  logic [NUM_SOURCES-1:0]   w_stall;
  logic                     w_grant_valid;
  logic [SRC_ID_WIDTH-1:0]  w_winner;
  logic [SRC_ID_WIDTH-1:0]  w_cand;

  logic                     r_enable;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic [SRC_ID_WIDTH-1:0]  r_source;
  logic [SRC_ID_WIDTH-1:0]  r_rr;
  logic                     r_overflow;

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_queue
    decode_holding_queue #(.WIDTH(PAYLOAD_WIDTH)) u_queue (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .i_push  (bus.enable_i[s]),
      .i_pop   (w_pop[s]),
      .i_data  (bus.payload_i[s*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .o_data  (w_head[s]),
      .o_count (w_count[s]),
      .o_full  (w_full[s]),
      .o_empty (w_empty[s]),
      .o_drop  (w_drop[s])
    );
  end

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    w_grant_valid = 1'b0;
    w_winner      = '0;
    w_cand        = '0;
    if (!bus.stall_i) begin
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        w_cand = rr_next_idx(r_rr, i);
        if (!w_grant_valid && !w_empty[w_cand]) begin
          w_grant_valid = 1'b1;
          w_winner      = w_cand;
        end
      end
    end
  end

  // count==1 without a grant still stalls: the decoder's registered output may land one more push.
  always_comb begin
    w_pop   = '0;
    w_stall = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      w_pop[s]   = w_grant_valid && (w_winner == SRC_ID_WIDTH'(s));
      w_stall[s] = w_full[s] || ((w_count[s] == 2'd1) && !w_pop[s]);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_enable   <= 1'b0;
      r_payload  <= '0;
      r_source   <= '0;
      r_rr       <= SRC_ID_WIDTH'(NUM_SOURCES - 1);
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow || (|w_drop);
      if (!bus.stall_i) begin
        r_enable <= w_grant_valid;
        if (w_grant_valid) begin
          r_payload <= w_head[w_winner];
          r_source  <= w_winner;
          r_rr      <= w_winner;
        end
      end
    end
  end

  assign bus.stall_o    = w_stall;
  assign bus.enable_o   = r_enable;
  assign bus.payload_o  = r_payload;
  assign bus.source_o   = r_source;
  assign bus.overflow_o = r_overflow;
endmodule
